hex_scan_ctrl: RTL and testbench
================================

// Module: hex_scan_ctrl
// PURPOSE
//  Scan controller for a 4-digit multiplexed 7-segment display; sequences the hex register of the
//  LED/hex IO peripheral onto the physical digits. Latches a 16-bit hex word once per frame,
//  decodes one nibble per digit slot and drives active-low segment/digit lines with per-slot PWM
//  brightness. Sits between the IO peripheral's hex/LED registers and the board pins.
// PARAMETERS
//  CPrescale  16'd250  enabled clocks per PWM tick; legal range 1..65535
// PORTS
//  AClkH      in   1   system clock
//  AResetHN   in   1   reset, asynchronous, active-low
//  AClkHEn    in   1   clock enable; all state frozen while low
//  AEnable    in   1   scan enable; low = display blanked, counters held at 0
//  ADataHex   in   16  hex word; nibble n -> digit n (digit 0 = [3:0])
//  ADotMask   in   4   decimal point per digit, 1 = lit
//  ABright    in   4   brightness 0..15 (0 = dark, 15 = 15/16 duty)
//  ASegN      out  8   segments, active-low: [6:0] = g..a, [7] = dp
//  ADigitN    out  4   digit select, active-low, one-hot-low or all high
//  AFrame     out  1   one-cycle pulse at the end of each full 4-digit frame
// BEHAVIOUR
//  Reset (async, AResetHN=0): ASegN=8'hFF, ADigitN=4'hF, AFrame=0; prescaler, phase (4b), digit (2b)
//   and the latched word/dots/brightness all cleared to 0.
//  Only AClkHEn=1 cycles count as "enabled cycles"; with AClkHEn=0 every register holds.
//  Prescaler counts 0..CPrescale-1 on enabled cycles; tick = enabled cycle with count==CPrescale-1,
//   then wraps to 0. CPrescale=1 -> tick on every enabled cycle.
//  Phase 0..15 increments on tick; on phase 15 + tick: phase->0, digit->digit+1 (3 wraps to 0).
//  Frame latch: when digit=3, phase=15 and tick occur together (and at leaving disable), capture ADataHex,
//   ADotMask, ABright; whole next frame uses the captured copy (no tearing). AFrame=1 on the
//   following enabled cycle only.
//  Output drive: lit = (phase < latched bright). Phase 15 therefore always dark (ghost guard).
//   lit:  ADigitN = ~(4'b0001<<digit), ASegN = ~{dot[digit], seg7(nibble[digit])}.
//   dark: ADigitN = 4'hF, ASegN = 8'hFF.
//  seg7 (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//  Outputs are registered: they reflect the counter/latch state of the previous enabled cycle
//   (1 enabled-cycle latency); never more than one ADigitN bit low.
//  AEnable=0 (sampled on enabled cycles): next enabled cycle ASegN=FF, ADigitN=F, AFrame=0;
//   prescaler/phase/digit forced to 0. AEnable 0->1: on that enabled cycle latch inputs, frame
//   starts at digit 0 phase 0; no AFrame pulse for the aborted frame.
//  Brightness/data changes mid-frame have no effect until the next frame latch.
//  Reset mid-frame: immediate blank, restart at digit 0 after release; latched data cleared.
// CONFIGURATION
//  HEX_SCAN_LZB_EN defined: leading-zero blanking. Digit n (n=3..1) blanked in a-g when latched
//   nibbles n..3 are all zero; digit 0 never blanked; dp still follows ADotMask; blanking evaluated
//   on the latched word. Not defined: all four digits always decoded.
// TESTING
//  1 Reset: hold AResetHN=0, toggle inputs -> ASegN=FF, ADigitN=F, AFrame=0 throughout.
//  2 CPrescale=1, AClkHEn=1, AEnable=1, ADataHex=16'h12AF, ABright=15, dots=0 -> digit0 ASegN=8E
//    (F) for 15 cycles then dark 1 cycle; digits 1..3 show 88 (A), A4 (2), F9 (1); AFrame every 64 cycles.
//  3 ABright=4, CPrescale=3 -> per digit slot ADigitN low for exactly 12 enabled clocks of 48;
//    ABright=0 -> ADigitN stays 4'hF for a whole frame.
//  4 Change ADataHex 1234->5678 mid-frame -> current frame unchanged; new value from next frame;
//    AClkHEn=0 bursts stretch timing proportionally with no state change.
//  5 Drop AEnable at digit 2 phase 7 -> blank next enabled cycle; re-enable -> restart digit 0 phase 0,
//    no AFrame for aborted frame.
//  6 HEX_SCAN_LZB_EN, ADataHex=16'h0040, ADotMask=4'b1000 -> digit3 ASegN=7F (dp only), digit2 dark
//    segs (FF), digit1 99 (4), digit0 C0 (0); without macro digit3=40, digit2=C0.

Source files
------------

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: 4-digit multiplexed 7-segment scan controller with per-slot PWM brightness.
// Define HEX_SCAN_LZB_EN to enable leading-zero blanking of digits 3..1.
module hex_scan_ctrl #(
  parameter logic [15:0] CPrescale = 16'd250
) (
  input  logic        AClkH,
  input  logic        AResetHN,
  input  logic        AClkHEn,
  input  logic        AEnable,
  input  logic [15:0] ADataHex,
  input  logic [3:0]  ADotMask,
  input  logic [3:0]  ABright,
  output logic [7:0]  ASegN,
  output logic [3:0]  ADigitN,
  output logic        AFrame
);
  logic [15:0] pre_q, pre_d, word_q, word_d;
  logic [3:0]  phase_q, phase_d, dot_q, dot_d, bright_q, bright_d, dig_q, dig_d;
  logic [1:0]  digit_q, digit_d;
  logic [7:0]  seg_q, seg_d;
  logic        frame_q, frame_d, run_q, run_d;
  logic        tick, wrap, eof, lit, blank;
  logic [3:0]  nib;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    tick = pre_q == CPrescale - 16'd1;
    wrap = tick && phase_q == 4'hF;
    eof  = wrap && digit_q == 2'd3;
    nib  = word_q[{digit_q, 2'b00} +: 4];
    // Outputs stay dark on the restart cycle so stale latched data never flashes.
    lit  = run_q && (phase_q < bright_q);
`ifdef HEX_SCAN_LZB_EN
    blank = digit_q == 2'd3 ? word_q[15:12] == 4'h0 :
            digit_q == 2'd2 ? word_q[15:8] == 8'h00 :
            digit_q == 2'd1 ? word_q[15:4] == 12'h000 : 1'b0;
`else
    blank = 1'b0;
`endif
    pre_d    = pre_q;
    phase_d  = phase_q;
    digit_d  = digit_q;
    word_d   = word_q;
    dot_d    = dot_q;
    bright_d = bright_q;
    run_d    = AEnable;
    frame_d  = AEnable && eof;
    seg_d    = AEnable && lit ? ~{dot_q[digit_q], blank ? 7'h00 : seg7(nib)} : 8'hFF;
    dig_d    = AEnable && lit ? ~(4'b0001 << digit_q) : 4'hF;
    if (!AEnable) begin
      pre_d   = '0;
      phase_d = '0;
      digit_d = '0;
    end else if (run_q) begin
      pre_d   = tick ? 16'd0 : pre_q + 16'd1;
      phase_d = tick ? phase_q + 4'd1 : phase_q;
      digit_d = wrap ? digit_q + 2'd1 : digit_q;
    end
    if (AEnable && (!run_q || eof)) begin
      word_d   = ADataHex;
      dot_d    = ADotMask;
      bright_d = ABright;
    end
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      pre_q    <= '0;
      phase_q  <= '0;
      digit_q  <= '0;
      word_q   <= '0;
      dot_q    <= '0;
      bright_q <= '0;
      run_q    <= 1'b0;
      frame_q  <= 1'b0;
      seg_q    <= 8'hFF;
      dig_q    <= 4'hF;
    end else if (AClkHEn) begin
      pre_q    <= pre_d;
      phase_q  <= phase_d;
      digit_q  <= digit_d;
      word_q   <= word_d;
      dot_q    <= dot_d;
      bright_q <= bright_d;
      run_q    <= run_d;
      frame_q  <= frame_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
    end
  end

  assign ASegN   = seg_q;
  assign ADigitN = dig_q;
  assign AFrame  = frame_q;
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: directed checks of hex_scan_ctrl at prescale 1 (u1) and prescale 3 (u3).
module tb_hex_scan_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, ce = 1'b1, en = 1'b0;
  logic [15:0] data = 16'h0;
  logic [3:0]  dots = 4'h0, bright = 4'h0;
  logic [7:0]  seg1, seg3;
  logic [3:0]  dig1, dig3;
  logic        frm1, frm3;
  int n = 0, miss = 0;
  logic [7:0] t2 [4] = '{8'h8E, 8'h88, 8'hA4, 8'hF9};

  always #5 clk = ~clk;

  hex_scan_ctrl #(.CPrescale(16'd1)) u1 (.AClkH(clk), .AResetHN(rst_n), .AClkHEn(ce), .AEnable(en),
    .ADataHex(data), .ADotMask(dots), .ABright(bright), .ASegN(seg1), .ADigitN(dig1), .AFrame(frm1));
  hex_scan_ctrl #(.CPrescale(16'd3)) u3 (.AClkH(clk), .AResetHN(rst_n), .AClkHEn(ce), .AEnable(en),
    .ADataHex(data), .ADotMask(dots), .ABright(bright), .ASegN(seg3), .ADigitN(dig3), .AFrame(frm3));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic restart();
    en = 1'b0;
    step(1);
    en = 1'b1;
    step(1);
  endtask

  initial begin
    int c [4];
    int other, fr;
    // reset held while inputs toggle
    #1;
    for (int i = 0; i < 5; i++) begin
      en = i[0]; data = 16'h1111 * i; bright = 4'hF; dots = 4'hF;
      step(1);
      chk("rst_seg1", seg1, 8'hFF); chk("rst_dig1", dig1, 4'hF); chk("rst_frm1", frm1, 1'b0);
      chk("rst_seg3", seg3, 8'hFF); chk("rst_dig3", dig3, 4'hF); chk("rst_frm3", frm3, 1'b0);
    end
    rst_n = 1'b1;
    // full-brightness scan of 12AF at prescale 1
    data = 16'h12AF; bright = 4'hF; dots = 4'h0;
    restart();
    chk("t2_latch_dark", seg1, 8'hFF);
    for (int k = 2; k <= 66; k++) begin
      int idx, p, d;
      step(1);
      idx = k - 2; p = idx % 16; d = (idx / 16) % 4;
      chk("t2_seg", seg1, p < 15 ? t2[d] : 8'hFF);
      chk("t2_dig", dig1, p < 15 ? 4'hF ^ (4'b0001 << d) : 4'hF);
      chk("t2_frm", frm1, k == 65);
    end
    // brightness 4 at prescale 3, then 0 on the next frame
    bright = 4'd4; data = 16'h8888;
    restart();
    bright = 4'd0;
    c = '{0, 0, 0, 0}; other = 0; fr = 0;
    for (int k = 0; k < 192; k++) begin
      step(1);
      if (dig3 == 4'hE) c[0]++; else if (dig3 == 4'hD) c[1]++;
      else if (dig3 == 4'hB) c[2]++; else if (dig3 == 4'h7) c[3]++;
      else if (dig3 != 4'hF) other++;
      if (frm3) fr++;
    end
    for (int d = 0; d < 4; d++) chk("t3_lowcnt", 16'(c[d]), 16'd12);
    chk("t3_onehot", 16'(other), 16'd0);
    chk("t3_frames", 16'(fr), 16'd1);
    other = 0;
    for (int k = 0; k < 192; k++) begin
      step(1);
      if (dig3 != 4'hF) other++;
    end
    chk("t3_bright0", 16'(other), 16'd0);
    // mid-frame data change plus clock-enable stalls
    data = 16'h1234; bright = 4'hF;
    restart();
    step(1);
    chk("t4_d0_seg", seg1, 8'h99); chk("t4_d0_dig", dig1, 4'hE);
    step(8);
    data = 16'h5678; ce = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("t4_stall_seg", seg1, 8'h99); chk("t4_stall_dig", dig1, 4'hE);
    end
    ce = 1'b1;
    step(8);
    chk("t4_d1_seg", seg1, 8'hB0); chk("t4_d1_dig", dig1, 4'hD);
    step(32);
    chk("t4_d3_seg", seg1, 8'hF9); chk("t4_d3_dig", dig1, 4'h7);
    step(15);
    chk("t4_frame", frm1, 1'b1);
    ce = 1'b0;
    step(3);
    chk("t4_frame_hold", frm1, 1'b1);
    ce = 1'b1;
    step(1);
    chk("t4_frame_end", frm1, 1'b0);
    chk("t4_new_seg", seg1, 8'h80); chk("t4_new_dig", dig1, 4'hE);
    // disable at digit 2 phase 7, then restart
    data = 16'h12AF;
    restart();
    step(39);
    chk("t5_pre_seg", seg1, 8'hA4); chk("t5_pre_dig", dig1, 4'hB);
    en = 1'b0;
    step(1);
    chk("t5_off_seg", seg1, 8'hFF); chk("t5_off_dig", dig1, 4'hF); chk("t5_off_frm", frm1, 1'b0);
    step(30);
    chk("t5_held_seg", seg1, 8'hFF); chk("t5_held_frm", frm1, 1'b0);
    en = 1'b1;
    step(1);
    chk("t5_latch_dark", seg1, 8'hFF);
    step(1);
    chk("t5_re_seg", seg1, 8'h8E); chk("t5_re_dig", dig1, 4'hE);
    fr = 0;
    for (int k = 0; k < 62; k++) begin
      step(1);
      if (frm1) fr++;
    end
    chk("t5_no_frame", 16'(fr), 16'd0);
    step(1);
    chk("t5_frame", frm1, 1'b1);
    // leading-zero blanking pattern
    data = 16'h0040; dots = 4'b1000;
    restart();
    step(1);
    chk("t6_d0", seg1, 8'hC0);
    step(16);
    chk("t6_d1", seg1, 8'h99);
    step(16);
`ifdef HEX_SCAN_LZB_EN
    chk("t6_d2", seg1, 8'hFF);
`else
    chk("t6_d2", seg1, 8'hC0);
`endif
    chk("t6_d2_dig", dig1, 4'hB);
    step(16);
`ifdef HEX_SCAN_LZB_EN
    chk("t6_d3", seg1, 8'h7F);
`else
    chk("t6_d3", seg1, 8'h40);
`endif
    chk("t6_d3_dig", dig1, 4'h7);
    // asynchronous reset mid-frame
    step(3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_seg", seg1, 8'hFF); chk("rst_mid_dig", dig1, 4'hF); chk("rst_mid_frm", frm1, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("rst_rel_dark", seg1, 8'hFF);
    step(1);
    chk("rst_rel_d0", seg1, 8'hC0); chk("rst_rel_dig", dig1, 4'hE);
    $display("== %0d vectors applied, %0d miscompares ==", n, miss);
    $finish;
  end
endmodule
